// File: rtl/tracker_pkg.sv
// Shared definitions for the cursor position tracker: FSM encoding and
// command-word field positions.
package tracker_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLatch   = 2'd1,
        StEval    = 2'd2,
        StWaitRel = 2'd3
    } state_e;

    localparam int unsigned AXIS_BIT = 0;
    localparam int unsigned OP_BIT   = 1;
    localparam int unsigned STEP_MSB = 3;
    localparam int unsigned STEP_LSB = 2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer; the output only
// follows the synchronized button after it holds a new level long enough.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_db_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, btn_s_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_s_q != db_q) begin
            // The edge that completes the hold period toggles the output.
            if (cnt_q == LastCnt) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            btn_s_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/five_bit_adder.sv
// Combinational position adder: offsets both axes by the command step,
// with bit 4 flagging carry past 15 or borrow below 0.
module five_bit_adder
    import tracker_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [3:0] num,
    output logic [4:0] sum_x,
    output logic [4:0] sum_y
);

    logic [4:0] step;

    always_comb begin
        step  = {3'b000, num[STEP_MSB:STEP_LSB]};
        sum_x = num[OP_BIT] ? ({1'b0, x} - step) : ({1'b0, x} + step);
        sum_y = num[OP_BIT] ? ({1'b0, y} - step) : ({1'b0, y} + step);
    end

endmodule

// File: rtl/position_tracker.sv
// Cursor position tracker: latches a command on each debounced press and
// commits the external adder's result one cycle later, rejecting overflow.
module position_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [3:0]  X_INIT          = 4'd8,
    parameter logic [3:0]  Y_INIT          = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] num,
    input  logic [4:0] sum_x,
    input  logic [4:0] sum_y,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [3:0] num_q,
    output logic       busy,
    output logic       err,
    output logic [7:0] move_cnt,
    output logic [7:0] rej_cnt
);

    state_e     state_q, state_d;
    logic       btn_db, db_prev_q;
    logic [3:0] x_q, x_d, y_q, y_d, cmd_q, cmd_d;
    logic       err_q, err_d;
    logic [7:0] mv_q, mv_d, rj_q, rj_d;
    logic [4:0] s;
    logic [1:0] step;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn),
        .btn_db_o(btn_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (btn_db && !db_prev_q) state_d = StLatch;
            StLatch:   state_d = StEval;
            StEval:    state_d = StWaitRel;
            StWaitRel: if (!btn_db) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_comb begin
        s     = cmd_q[AXIS_BIT] ? sum_x : sum_y;
        step  = cmd_q[STEP_MSB:STEP_LSB];
        x_d   = x_q;
        y_d   = y_q;
        cmd_d = cmd_q;
        err_d = err_q;
        mv_d  = mv_q;
        rj_d  = rj_q;
        if (state_q == StLatch) begin
            cmd_d = num;
        end
        // A zero step is a pure no-op: counters and err are left alone.
        if (state_q == StEval && step != 2'd0) begin
            if (!s[4]) begin
                if (cmd_q[AXIS_BIT]) x_d = s[3:0];
                else                 y_d = s[3:0];
                if (mv_q != 8'hFF) mv_d = mv_q + 8'd1;
                err_d = 1'b0;
            end else begin
                if (rj_q != 8'hFF) rj_d = rj_q + 8'd1;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev_q <= 1'b0;
            x_q       <= X_INIT;
            y_q       <= Y_INIT;
            cmd_q     <= 4'd0;
            err_q     <= 1'b0;
            mv_q      <= 8'd0;
            rj_q      <= 8'd0;
        end else begin
            db_prev_q <= btn_db;
            x_q       <= x_d;
            y_q       <= y_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            mv_q      <= mv_d;
            rj_q      <= rj_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign num_q    = cmd_q;
    assign err      = err_q;
    assign move_cnt = mv_q;
    assign rej_cnt  = rj_q;

endmodule

// File: tb/tb_position_tracker.sv
// Closed-loop bench: tracker plus adder, driven by directed press vectors
// and hand-written bounce, reset and saturation sequences.
module tb_position_tracker;

    localparam int unsigned D = 16;

    logic       clk, rst, btn;
    logic [3:0] num, x, y, num_q;
    logic [4:0] sum_x, sum_y;
    logic       busy, err;
    logic [7:0] move_cnt, rej_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] num;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [7:0] emv;
        logic [7:0] erj;
        logic       eerr;
    } vec_t;

    vec_t vecs[10];

    position_tracker #(
        .DEBOUNCE_CYCLES(D),
        .X_INIT         (4'd8),
        .Y_INIT         (4'd8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .num     (num),
        .sum_x   (sum_x),
        .sum_y   (sum_y),
        .x       (x),
        .y       (y),
        .num_q   (num_q),
        .busy    (busy),
        .err     (err),
        .move_cnt(move_cnt),
        .rej_cnt (rej_cnt)
    );

    five_bit_adder u_adder (
        .x    (x),
        .y    (y),
        .num  (num_q),
        .sum_x(sum_x),
        .sum_y(sum_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                               input logic [7:0] emv, input logic [7:0] erj, input logic eerr);
        check({tag, ".x"}, 32'(x), 32'(ex));
        check({tag, ".y"}, 32'(y), 32'(ey));
        check({tag, ".move_cnt"}, 32'(move_cnt), 32'(emv));
        check({tag, ".rej_cnt"}, 32'(rej_cnt), 32'(erj));
        check({tag, ".err"}, 32'(err), 32'(eerr));
    endtask

    task automatic press(input logic [3:0] n);
        int k;
        @(negedge clk);
        num = n;
        btn = 1'b1;
        k = 0;
        while (!busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy_rise", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        btn = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        logic saw_busy;

        vecs[0] = '{4'b1110, 4'd11, 4'd5, 8'd2, 8'd0, 1'b0};
        vecs[1] = '{4'b1110, 4'd11, 4'd2, 8'd3, 8'd0, 1'b0};
        vecs[2] = '{4'b0110, 4'd11, 4'd1, 8'd4, 8'd0, 1'b0};
        vecs[3] = '{4'b1010, 4'd11, 4'd1, 8'd4, 8'd1, 1'b1};
        vecs[4] = '{4'b0001, 4'd11, 4'd1, 8'd4, 8'd1, 1'b1};
        vecs[5] = '{4'b0110, 4'd11, 4'd0, 8'd5, 8'd1, 1'b0};
        vecs[6] = '{4'b1101, 4'd14, 4'd0, 8'd6, 8'd1, 1'b0};
        vecs[7] = '{4'b0101, 4'd15, 4'd0, 8'd7, 8'd1, 1'b0};
        vecs[8] = '{4'b0101, 4'd15, 4'd0, 8'd7, 8'd2, 1'b1};
        vecs[9] = '{4'b1111, 4'd12, 4'd0, 8'd8, 8'd2, 1'b0};

        rst = 1'b1;
        btn = 1'b0;
        num = 4'd0;
        #1;
        check_state("reset", 4'd8, 4'd8, 8'd0, 8'd0, 1'b0);
        check("reset.num_q", 32'(num_q), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First press, counted edge by edge from the btn change.
        @(negedge clk);
        num = 4'b1101;
        btn = 1'b1;
        for (int i = 1; i <= int'(D) + 5; i++) begin
            @(negedge clk);
            if (i == int'(D) + 2) check("timing.busy_pre", 32'(busy), 32'd0);
            if (i == int'(D) + 3) check("timing.busy_latch", 32'(busy), 32'd1);
            if (i == int'(D) + 4) check("timing.x_pre", 32'(x), 32'd8);
            if (i == int'(D) + 5) check("timing.x_post", 32'(x), 32'd11);
        end
        btn = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timing.busy_fall", 32'(busy), 32'd0);
        check_state("add_x", 4'd11, 4'd8, 8'd1, 8'd0, 1'b0);

        for (int v = 0; v < 10; v++) begin
            press(vecs[v].num);
            check_state($sformatf("vec%0d", v), vecs[v].ex, vecs[v].ey, vecs[v].emv,
                        vecs[v].erj, vecs[v].eerr);
        end

        // Glitches one cycle short of the hold time must never register.
        saw_busy = 1'b0;
        num = 4'b0101;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            btn = 1'b1;
            for (int c = 0; c < int'(D) - 1; c++) begin
                @(negedge clk);
                if (busy) saw_busy = 1'b1;
            end
            btn = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (busy) saw_busy = 1'b1;
            end
        end
        repeat (int'(D) + 8) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("bounce.no_busy", 32'(saw_busy), 32'd0);
        check("bounce.move_cnt", 32'(move_cnt), 32'd8);

        // Long hold with num scrambled after the latch cycle.
        @(negedge clk);
        num = 4'b0101;
        btn = 1'b1;
        k = 0;
        while (!busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold.busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        for (int c = 0; c < 190; c++) begin
            num = (c % 2 == 0) ? 4'b1111 : 4'b1010;
            @(negedge clk);
        end
        btn = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold.busy_fall", 32'(busy), 32'd0);
        check_state("hold", 4'd13, 4'd0, 8'd9, 8'd2, 1'b0);
        check("hold.num_q", 32'(num_q), 32'b0101);

        // Reset asserted while the FSM sits in EVAL.
        @(negedge clk);
        num = 4'b0101;
        btn = 1'b1;
        k = 0;
        while (!busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_eval.busy_rise", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        btn = 1'b0;
        #1;
        check_state("rst_eval", 4'd8, 4'd8, 8'd0, 8'd0, 1'b0);
        check("rst_eval.num_q", 32'(num_q), 32'd0);
        check("rst_eval.busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (int'(D) + 8) @(negedge clk);
        check("rst_eval.settled_x", 32'(x), 32'd8);
        check("rst_eval.settled_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 256; i++) begin
            press((i % 2 == 0) ? 4'b0101 : 4'b0111);
            if (i == 254) check("sat.move_cnt_255", 32'(move_cnt), 32'd255);
        end
        check_state("sat", 4'd8, 4'd8, 8'd255, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/position_tracker.md
# position_tracker

Sequential stage wrapped around the combinational five-bit adder that updates the cursor position. Debounces the move push-button, freezes the 4-bit command word for the adder, and, one evaluation cycle later, commits the adder's `sum_x`/`sum_y` back into the position registers. A result with bit 4 set is an out-of-range move and is rejected. The registered `x`/`y` drive the adder inputs and the display logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16, cycles the synchronized button must hold a new level before it is accepted; 1,000,000 on the board.
- `X_INIT`, 4'd8, reset value of `x`.
- `Y_INIT`, 4'd8, reset value of `y`.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn`  in  1  raw, asynchronous move push-button; active high.
- `num`  in  4  command switches. Bit 0 selects the axis: 1 = x, 0 = y. Bit 1 is `op`: 0 = add, 1 = subtract. Bits 3:2 are the step, 0–3.
- `sum_x`  in  5  adder result for x.
- `sum_y`  in  5  adder result for y.
- `x`  out  4  registered x position; drives the adder.
- `y`  out  4  registered y position; drives the adder.
- `num_q`  out  4  latched command word; drives the adder's `num`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky: set on a rejected move, cleared by the next accepted move.
- `move_cnt`  out  8  accepted moves, saturating at 255.
- `rej_cnt`  out  8  rejected moves, saturating at 255.

## Operation
- **Button conditioning:**
  - `btn` passes through a 2-flop synchronizer to give `btn_s`.
  - The debounce counter counts while `btn_s` differs from `btn_db`; `btn_db` toggles when the count reaches `DEBOUNCE_CYCLES`.
  - The counter clears whenever `btn_s` equals `btn_db`.
- **FSM states:**
  - IDLE: on the rising edge of `btn_db` (registered previous value 0, current 1), go to LATCH.
  - LATCH: `num_q <= num`; go to EVAL.
  - EVAL: select `s = num_q[0] ? sum_x : sum_y` and `step = num_q[3:2]`.
    - If `step == 0`: no-op. No register, counter or `err` change.
    - Else if `s[4] == 0`: write `s[3:0]` into the selected axis. Increment `move_cnt` and clear `err`.
    - Else: positions unchanged. Increment `rej_cnt` and set `err`.
    - Go to WAIT_REL.
  - WAIT_REL: stay until `btn_db == 0`, then go to IDLE.
- **Range rule:** `s[4] = 1` means carry past 15 on an add, or borrow below 0 on a subtract. Valid positions are 0–15 only; the tracker never wraps.
- Exactly one axis changes per press. The other axis holds its value.
- `num` changes after LATCH are ignored until the next press.
- A held button produces one move only. Auto-repeat is not supported.
- **Reset:** asynchronous, effective at any state including mid-EVAL. Reset values:
  - `x = X_INIT`, `y = Y_INIT`
  - `num_q = 0`, `err = 0`, `move_cnt = 0`, `rej_cnt = 0`
  - FSM = IDLE, `btn_db = 0`, `btn_s` and synchronizer flops = 0, debounce counter = 0

## Timing
- Debounce latency: 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles from the `btn` edge to the `btn_db` change.
- From the edge where `btn_db` goes 1:
  - FSM enters LATCH at edge +1.
  - `num_q` is valid after edge +2.
  - `x`, `y`, counters and `err` update at edge +3.
- The adder is combinational from `x`, `y`, `num_q`. Its result is stable for the whole EVAL cycle; no extra wait state.
- `busy` rises at edge +1 and falls one cycle after `btn_db` goes 0.
- Glitches shorter than `DEBOUNCE_CYCLES` are ignored entirely.
- Counters at 255 hold at 255; the `err` update still occurs.

## Structure
- Shared package `tracker_pkg` holds:
  - FSM state encoding (IDLE, LATCH, EVAL, WAIT_REL; 2-bit enum).
  - Field constants: `AXIS_BIT = 0`, `OP_BIT = 1`, `STEP_MSB = 3`, `STEP_LSB = 2`.
- Sub-module `btn_debounce`: synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`; outputs `btn_db`. The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- The FSM, position registers and counters live in the top level.
- The bench instantiates `five_bit_adder` with the tracker in a closed loop.

## Test plan
- **Reset:** assert `rst` mid-EVAL → `x = 8`, `y = 8`, `num_q = 0`, counters 0, `err = 0`, `busy = 0` immediately, without waiting for a clock edge.
- **Add on x:** `num = 4'b1101` (x, add, step 3), one clean press from `x = 8` → `x = 11`, `y = 8`, `move_cnt = 1`, `err = 0`. The update lands exactly 3 edges after `btn_db` rises.
- **Subtract on y:** `num = 4'b1010` (y, subtract, step 2) from `y = 1` → rejected. `y` stays 1, `rej_cnt = 1`, `err = 1`. A next press with `num = 4'b0110` (step 1) → `y = 0`, `err = 0`.
- **Bounce:** `btn` pulses of `DEBOUNCE_CYCLES − 1` cycles, then held high for 200 cycles while `num` toggles after LATCH → exactly one move, using `num` as sampled in LATCH.
- **Step zero:** `num = 4'b0001` (step 0), one press → no change to positions, counters or `err`; `busy` pulses.
- **Saturation:** 256 accepted presses alternating x +1 and x −1 → `move_cnt` stops at 255 and `x` returns to 8.
